// File: rtl/mdu_param.sv
// Multiply/divide unit owning HI/LO: MULT/DIV/MADD/MSUB with configurable
// latency, plus single-cycle MTHI/MTLO writes. busy feeds the decode stall.
module mdu_param #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             start,
   input  logic             int_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             div_zero
);

   localparam int unsigned DW      = 2 * WIDTH;
   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [3:0]      op_q, op_q_n;
   logic [DW-1:0]   res, res_n;
   logic [WIDTH-1:0] hi_n, lo_n;
   logic            busy_n, div_zero_n;

   logic [DW-1:0]    prod_s, prod_u, res_c, hilo_acc;
   logic [WIDTH-1:0] a_mag, b_mag, bs_safe, bu_safe;
   logic [WIDTH-1:0] uq_s, ur_s, q_s, r_s, q_u, r_u;
   logic             op_is_start, op_is_div;

   // Result datapath evaluated on the operands present at the accept edge
   always_comb begin
      prod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      a_mag   = a[WIDTH-1] ? -a : a;
      b_mag   = b[WIDTH-1] ? -b : b;
      // Divisor forced to 1 when zero so the divider never sees b==0
      bs_safe = (b == '0) ? WIDTH'(1) : b_mag;
      bu_safe = (b == '0) ? WIDTH'(1) : b;
      uq_s    = a_mag / bs_safe;
      ur_s    = a_mag % bs_safe;
      // MIN / -1 falls out naturally: magnitude 2^(W-1) re-encodes as MIN
      q_s     = (a[WIDTH-1] ^ b[WIDTH-1]) ? -uq_s : uq_s;
      r_s     = a[WIDTH-1] ? -ur_s : ur_s;
      q_u     = a / bu_safe;
      r_u     = a % bu_safe;
      res_c   = '0;
      case (op)
         OP_MULT, OP_MADD, OP_MSUB:    res_c = prod_s;
         OP_MULTU, OP_MADDU, OP_MSUBU: res_c = prod_u;
         OP_DIV:                       res_c = {r_s, q_s};
         OP_DIVU:                      res_c = {r_u, q_u};
         default:                      res_c = '0;
      endcase
   end

   // Start-able op decode
   always_comb begin
      op_is_start = 1'b0;
      op_is_div   = 1'b0;
      case (op)
         OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_is_start = 1'b1;
         OP_DIV, OP_DIVU: begin
            op_is_start = 1'b1;
            op_is_div   = 1'b1;
         end
         default: ;
      endcase
   end

   // Next-state: accept / MTHI / MTLO in IDLE, countdown and HI/LO commit in RUN
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      op_q_n     = op_q;
      res_n      = res;
      hi_n       = hi;
      lo_n       = lo;
      busy_n     = busy;
      div_zero_n = div_zero;
      hilo_acc   = {hi, lo};
      case (state)
         S_IDLE: begin
            if (start && !int_req && op_is_start) begin
               state_n    = S_RUN;
               cnt_n      = op_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
               busy_n     = 1'b1;
               op_q_n     = op;
               res_n      = res_c;
               div_zero_n = op_is_div && (b == '0);
            end else if (!start && !int_req) begin
               if (op == OP_MTHI) hi_n = a;
               if (op == OP_MTLO) lo_n = a;
            end
         end
         S_RUN: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n = S_IDLE;
               busy_n  = 1'b0;
               case (op_q)
                  OP_MULT, OP_MULTU:  hilo_acc = res;
                  OP_DIV, OP_DIVU:    hilo_acc = div_zero ? {hi, lo} : res;
                  OP_MADD, OP_MADDU:  hilo_acc = {hi, lo} + res;
                  OP_MSUB, OP_MSUBU:  hilo_acc = {hi, lo} - res;
                  default:            hilo_acc = {hi, lo};
               endcase
               {hi_n, lo_n} = hilo_acc;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         res      <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         op_q     <= op_q_n;
         res      <= res_n;
         hi       <= hi_n;
         lo       <= lo_n;
         busy     <= busy_n;
         div_zero <= div_zero_n;
      end
   end

endmodule

// File: tb/tb_mdu_param.sv
// Scoreboard bench for mdu_param: stimulus pushes expected HI/LO/div_zero and
// busy length; monitors pop on every busy fall or explicit check request.
module tb_mdu_param;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] a, b;
   logic [3:0]  op;
   logic        start, int_req;
   logic [31:0] hi, lo;
   logic        busy, div_zero;

   logic [7:0]  a8, b8;
   logic [3:0]  op8;
   logic        start8, int_req8;
   logic [7:0]  hi8, lo8;
   logic        busy8, dz8;

   exp_t q[$];
   exp_t q8[$];
   int   checks = 0;
   int   errors = 0;
   bit   check_req = 0;
   bit   busy_prev = 0, busy8_prev = 0;
   int   bcnt = 0, bcnt8 = 0;

   mdu_param #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u_dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
      .int_req(int_req), .hi(hi), .lo(lo), .busy(busy), .div_zero(div_zero)
   );

   mdu_param #(.WIDTH(8), .MULT_LAT(1), .DIV_LAT(3)) u_dut8 (
      .clk(clk), .reset(reset), .a(a8), .b(b8), .op(op8), .start(start8),
      .int_req(int_req8), .hi(hi8), .lo(lo8), .busy(busy8), .div_zero(dz8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s %s actual=%h required=%h", nm, fld, act, exp_v);
      end
   endtask

   // Monitor for the 32-bit unit
   always @(negedge clk) begin
      exp_t e;
      bit   fall;
      fall = busy_prev && (busy === 1'b0);
      if (fall || check_req) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event actual=busy_fall required=no_event");
         end else begin
            e = q.pop_front();
            cmp(e.name, "hi", hi, e.hi);
            cmp(e.name, "lo", lo, e.lo);
            cmp(e.name, "div_zero", 32'(div_zero), 32'(e.dz));
            if (fall) cmp(e.name, "busy_cycles", 32'(bcnt), 32'(e.lat));
            else      cmp(e.name, "busy", 32'(busy), 32'd0);
         end
         check_req = 1'b0;
      end
      if (fall) bcnt = 0;
      if (busy === 1'b1) bcnt++;
      busy_prev = (busy === 1'b1);
   end

   // Monitor for the 8-bit unit
   always @(negedge clk) begin
      exp_t e;
      if (busy8_prev && (busy8 === 1'b0)) begin
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event8 actual=busy_fall required=no_event");
         end else begin
            e = q8.pop_front();
            cmp(e.name, "hi", 32'(hi8), e.hi);
            cmp(e.name, "lo", 32'(lo8), e.lo);
            cmp(e.name, "busy_cycles", 32'(bcnt8), 32'(e.lat));
         end
         bcnt8 = 0;
      end
      if (busy8 === 1'b1) bcnt8++;
      busy8_prev = (busy8 === 1'b1);
   end

   task automatic push(input string nm, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int lat);
      exp_t e;
      e.name = nm; e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = lat;
      q.push_back(e);
   endtask

   task automatic issue(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int lat);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      push(nm, ehi, elo, edz, lat);
      @(negedge clk);
      start = 1'b0; op = 4'd0;
   endtask

   task automatic issue8(input string nm, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] ehi, input logic [7:0] elo, input int lat);
      exp_t e;
      @(negedge clk);
      op8 = o; a8 = x; b8 = y; start8 = 1'b1;
      e.name = nm; e.hi = 32'(ehi); e.lo = 32'(elo); e.dz = 1'b0; e.lat = lat;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0; op8 = 4'd0;
   endtask

   task automatic drive1(input logic [3:0] o, input logic [31:0] x, input logic st, input logic ir);
      @(negedge clk);
      op = o; a = x; start = st; int_req = ir;
      @(negedge clk);
      op = 4'd0; start = 1'b0; int_req = 1'b0;
   endtask

   task automatic check_now(input string nm, input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      push(nm, ehi, elo, edz, 0);
      @(posedge clk);
      #1 check_req = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm, input logic which8);
      int n = 0;
      while (((which8 ? busy8 : busy) !== 1'b0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL %s timeout actual=busy_after_%0d_cycles required=idle", nm, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; a = '0; b = '0; op = '0; start = 1'b0; int_req = 1'b0;
      a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0; int_req8 = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check_now("reset_state", 32'h0, 32'h0, 1'b0);
      reset = 1'b0;

      // Signed multiply, negative operand
      issue("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 5);
      wait_idle("mult_neg", 1'b0);

      // MTHI/MTLO then accumulate
      drive1(4'd5, 32'h1234_5678, 1'b0, 1'b0);
      check_now("mthi", 32'h1234_5678, 32'hFFFF_FFFA, 1'b0);
      drive1(4'd6, 32'h9ABC_DEF0, 1'b0, 1'b0);
      check_now("mtlo", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      // 0x12345678_9ABCDEF0 + 0x00000001_FFFFFFFE
      issue("maddu", 4'd8, 32'hFFFF_FFFF, 32'd2, 32'h1234_567A, 32'h9ABC_DEEE, 1'b0, 5);
      wait_idle("maddu", 1'b0);
      issue("msub", 4'd9, 32'd1, 32'd1, 32'h1234_567A, 32'h9ABC_DEED, 1'b0, 5);
      wait_idle("msub", 1'b0);

      // Signed divide: truncation toward zero and MIN / -1
      issue("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 10);
      wait_idle("div_neg", 1'b0);
      issue("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 10);
      wait_idle("div_ovf", 1'b0);

      // Divide by zero leaves HI/LO, sets div_zero until next accept
      drive1(4'd5, 32'd5, 1'b0, 1'b0);
      drive1(4'd6, 32'd6, 1'b0, 1'b0);
      check_now("preset_5_6", 32'd5, 32'd6, 1'b0);
      issue("divu_zero", 4'd4, 32'd100, 32'd0, 32'd5, 32'd6, 1'b1, 10);
      wait_idle("divu_zero", 1'b0);
      issue("multu_clr_dz", 4'd2, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 5);
      wait_idle("multu_clr_dz", 1'b0);

      // Start and MTHI ignored while busy
      issue("mult_busy", 4'd1, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 5);
      op = 4'd1; a = 32'd100; b = 32'd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op = 4'd5; a = 32'h0000_DEAD;
      @(negedge clk);
      op = 4'd0;
      wait_idle("mult_busy", 1'b0);

      // Blocked by int_req, bad op, and start priority over MTHI
      drive1(4'd1, 32'd9, 1'b1, 1'b1);
      check_now("start_int_req", 32'd0, 32'd42, 1'b0);
      drive1(4'd6, 32'h1234, 1'b0, 1'b1);
      check_now("mtlo_int_req", 32'd0, 32'd42, 1'b0);
      drive1(4'd11, 32'd9, 1'b1, 1'b0);
      check_now("start_bad_op", 32'd0, 32'd42, 1'b0);
      drive1(4'd5, 32'h5555, 1'b1, 1'b0);
      check_now("start_over_mthi", 32'd0, 32'd42, 1'b0);

      // Async reset three cycles into a divide
      drive1(4'd5, 32'hABCD, 1'b0, 1'b0);
      check_now("mthi_pre_reset", 32'hABCD, 32'd42, 1'b0);
      issue("div_reset", 4'd3, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 3);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #1 reset = 1'b0;
      issue("multu_after_reset", 4'd2, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 5);
      wait_idle("multu_after_reset", 1'b0);

      // 8-bit instance, single-cycle multiply
      issue8("mult8_min", 4'd1, 8'h80, 8'h80, 8'h40, 8'h00, 1);
      wait_idle("mult8_min", 1'b1);
      issue8("multu8_ff", 4'd2, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1);
      wait_idle("multu8_ff", 1'b1);
      issue8("div8_neg", 4'd3, 8'h81, 8'h10, 8'hF1, 8'hF9, 3);
      wait_idle("div8_neg", 1'b1);

      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0 || q8.size() != 0) begin
         errors++;
         $display("FAIL queue_drain actual=%0d/%0d required=0/0", q.size(), q8.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
